// File: rtl/kgp_isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kgp_isa_pkg
//  Description : Shared KGPminiRISC instruction-word layout, encoding-format
//                codes and the state type of the instruction_encode loader.
//  Contents    : field bit positions, field widths, FMT_* codes, enc_state_e
//  Revision    : 1.0 - initial release
// ============================================================================
package kgp_isa_pkg;

   // Field positions inside the 32-bit instruction word
   localparam int OPC_MSB   = 31;
   localparam int RS_LSB    = 21;
   localparam int RT_LSB    = 16;
   localparam int SHAMT_LSB = 11;
   localparam int FUNC_MSB  = 4;

   // Field widths
   localparam int OPC_W = 6;
   localparam int REG_W = 5;
   localparam int IMM_W = 16;
   localparam int JMP_W = 26;

   // Encoding formats presented on the fmt input
   localparam logic [1:0] FMT_R   = 2'b00;
   localparam logic [1:0] FMT_I   = 2'b01;
   localparam logic [1:0] FMT_J26 = 2'b10;
   localparam logic [1:0] FMT_J16 = 2'b11;

   // Loader state machine
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } enc_state_e;

endpackage : kgp_isa_pkg
`default_nettype wire

// File: rtl/instruction_pack.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_pack
//  Description : Combinational packer: format code plus decoded fields in,
//                32-bit KGPminiRISC instruction word out. Fields that a
//                format does not use are ignored.
//  Ports       : fmt_i    - encoding format (R, I, J26, J16)
//                opcode_i - [31:26]
//                rs_i, rt_i, shamt_i, func_i - register/shift/function fields
//                imm_i    - 16-bit immediate or short jump offset
//                in1_i    - 26-bit jump address
//                word_o   - packed instruction
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_pack
   import kgp_isa_pkg::*;
(
   input  logic [1:0]       fmt_i,
   input  logic [OPC_W-1:0] opcode_i,
   input  logic [REG_W-1:0] rs_i,
   input  logic [REG_W-1:0] rt_i,
   input  logic [REG_W-1:0] shamt_i,
   input  logic [REG_W-1:0] func_i,
   input  logic [IMM_W-1:0] imm_i,
   input  logic [JMP_W-1:0] in1_i,
   output logic [31:0]      word_o
);

   always_comb begin
      word_o = '0;
      word_o[OPC_MSB -: OPC_W] = opcode_i;
      case (fmt_i)
         FMT_R: begin
            // bit 5 stays zero: func is only five bits wide
            word_o[RS_LSB    +: REG_W] = rs_i;
            word_o[RT_LSB    +: REG_W] = rt_i;
            word_o[SHAMT_LSB +: REG_W] = shamt_i;
            word_o[FUNC_MSB  :  0]     = func_i;
         end
         FMT_I: begin
            word_o[RS_LSB +: REG_W] = rs_i;
            word_o[RT_LSB +: REG_W] = rt_i;
            word_o[IMM_W-1:0]       = imm_i;
         end
         FMT_J26: begin
            word_o[JMP_W-1:0] = in1_i;
         end
         FMT_J16: begin
            // rt slot is forced to zero for the short jump form
            word_o[RS_LSB +: REG_W] = rs_i;
            word_o[IMM_W-1:0]       = imm_i;
         end
         default: ;
      endcase
   end

endmodule : instruction_pack
`default_nettype wire

// File: rtl/instruction_encode.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_encode
//  Description : Burst loader that encodes decoded field tuples into 32-bit
//                instructions and writes them to sequential instruction-
//                memory addresses, one registered write per accepted tuple.
//  Ports       : clk, rst (async, active-low)
//                start/base_addr/count   - burst request (IDLE only)
//                in_valid/in_ready + fmt, opcode, rs, rt, shamt, func, imm,
//                in1                     - field tuple handshake
//                imem_we/imem_addr/imem_wdata - memory write port
//                busy, done, err, words_written - status
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_encode
   import kgp_isa_pkg::*;
#(
   parameter int ADDR_W = 10
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        fmt,
   input  logic [5:0]        opcode,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        shamt,
   input  logic [4:0]        func,
   input  logic [15:0]       imm,
   input  logic [25:0]       in1,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_written
);

   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W + 2)'(DEPTH);

   enc_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [ADDR_W:0]   words_q, words_d;

   logic [31:0]       packed_word;
   logic [ADDR_W+1:0] end_sum;
   logic              accept;

   instruction_pack u_pack (
      .fmt_i    (fmt),
      .opcode_i (opcode),
      .rs_i     (rs),
      .rt_i     (rt),
      .shamt_i  (shamt),
      .func_i   (func),
      .imm_i    (imm),
      .in1_i    (in1),
      .word_o   (packed_word)
   );

   // Two extra bits so base_addr+count can never wrap before the range test
   assign end_sum  = {2'b00, base_addr} + {1'b0, count};
   assign in_ready = (state_q == ST_LOAD) && (remaining_q != '0);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      words_d     = words_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               words_d = '0;
               err_d   = 1'b0;
               if (count == '0) begin
                  state_d = ST_DONE;
               end else if (end_sum > DEPTH_W) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  addr_d      = base_addr;
                  remaining_d = count;
                  state_d     = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (accept) begin
               we_d        = 1'b1;
               waddr_d     = addr_q;
               wdata_d     = packed_word;
               addr_d      = addr_q + ADDR_W'(1);
               remaining_d = remaining_q - (ADDR_W + 1)'(1);
               // counted together with the strobe so both appear in one cycle
               words_d     = words_q + (ADDR_W + 1)'(1);
               if (remaining_q == (ADDR_W + 1)'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         words_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         words_q     <= words_d;
      end
   end

   assign imem_we       = we_q;
   assign imem_addr     = waddr_q;
   assign imem_wdata    = wdata_q;
   assign busy          = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
   assign done          = (state_q == ST_DONE);
   assign err           = err_q;
   assign words_written = words_q;

endmodule : instruction_encode
`default_nettype wire

// File: tb/tb_instruction_encode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_encode
//  Description : Self-checking bench for instruction_encode. A reference
//                encoder built from field arithmetic and a burst-level model
//                predict every write, status flag and counter value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_encode;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic              clk;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   count;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        fmt;
   logic [5:0]        opcode;
   logic [4:0]        rs, rt, shamt, func;
   logic [15:0]       imm;
   logic [25:0]       in1;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              busy, done, err;
   logic [ADDR_W:0]   words_written;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0]  f;
      logic [5:0]  op;
      logic [4:0]  rs, rt, sh, fn;
      logic [15:0] imm;
      logic [25:0] in1;
      logic [31:0] exp;
   } tup_t;

   tup_t dir_q[$];
   int   vpat[$];

   instruction_encode #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
      .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
      .rs(rs), .rt(rt), .shamt(shamt), .func(func), .imm(imm), .in1(in1),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .err(err), .words_written(words_written)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference encoder: place each field by its weight in the word
   function automatic logic [31:0] encode_ref(input logic [1:0] f, input logic [5:0] op,
         input logic [4:0] r_s, input logic [4:0] r_t, input logic [4:0] sh,
         input logic [4:0] fn, input logic [15:0] im, input logic [25:0] j);
      longint w;
      longint top;
      top = longint'(op) * 64'd67108864;
      case (f)
         2'd0:    w = top + longint'(r_s) * 2097152 + longint'(r_t) * 65536 + longint'(sh) * 2048 + longint'(fn);
         2'd1:    w = top + longint'(r_s) * 2097152 + longint'(r_t) * 65536 + longint'(im);
         2'd2:    w = top + longint'(j);
         default: w = top + longint'(r_s) * 2097152 + longint'(im);
      endcase
      return w[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_tuple(input bit directed, output logic [31:0] exp);
      tup_t t;
      if (directed && dir_q.size() > 0) begin
         t = dir_q.pop_front();
         fmt = t.f; opcode = t.op; rs = t.rs; rt = t.rt; shamt = t.sh;
         func = t.fn; imm = t.imm; in1 = t.in1;
         exp = t.exp;
      end else begin
         fmt = 2'($urandom); opcode = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom);
         shamt = 5'($urandom); func = 5'($urandom); imm = 16'($urandom); in1 = 26'($urandom);
         exp = encode_ref(fmt, opcode, rs, rt, shamt, func, imm, in1);
      end
   endtask

   // One complete burst against the model; poke drives a spurious start mid-burst
   task automatic do_burst(input int base, input int cnt, input bit directed, input bit poke);
      bit          legal;
      bit          exp_err;
      int          rem, addr, written, guard, pulses;
      bit          v;
      logic [31:0] exp;
      legal   = (cnt > 0) && (base + cnt <= DEPTH);
      exp_err = (cnt > 0) && !legal;
      base_addr = ADDR_W'(base);
      count     = (ADDR_W + 1)'(cnt);
      start     = 1'b1;
      tick();
      start = 1'b0;
      n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL start_err: got %b want %b (base %0d count %0d)", err, exp_err, base, cnt); end
      n_checks++; if (words_written !== '0) begin n_fail++; $display("FAIL start_clear_words: got %0d want 0", words_written); end
      n_checks++; if (busy !== legal) begin n_fail++; $display("FAIL start_busy: got %b want %b", busy, legal); end
      if (!legal) begin
         pulses   = 0;
         in_valid = 1'b1;
         for (int k = 0; k < 3; k++) begin
            if (done === 1'b1) pulses++;
            n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL nowrite_we: got %b want 0 (count %0d)", imem_we, cnt); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL nowrite_ready: got %b want 0", in_ready); end
            n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL nowrite_err: got %b want %b", err, exp_err); end
            tick();
         end
         in_valid = 1'b0;
         n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL nowrite_done_pulses: got %0d want 1", pulses); end
         return;
      end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL load_done_early: got %b want 0", done); end
      rem = cnt; addr = base; written = 0; guard = 0;
      while (rem > 0 && guard < 20000) begin
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b want 1 (remaining %0d)", in_ready, rem); end
         if (vpat.size() > 0) v = (vpat.pop_front() != 0);
         else                 v = ($urandom_range(0, 3) != 0);
         in_valid = v;
         drive_tuple(directed && v, exp);
         if (poke && guard == 1) begin
            start     = 1'b1;
            base_addr = ADDR_W'($urandom);
            count     = (ADDR_W + 1)'($urandom_range(1, 8));
         end
         tick();
         start    = 1'b0;
         in_valid = 1'b0;
         if (v) begin
            n_checks++; if (imem_we !== 1'b1) begin n_fail++; $display("FAIL write_we: got %b want 1", imem_we); end
            n_checks++; if (imem_addr !== ADDR_W'(addr)) begin n_fail++; $display("FAIL write_addr: got %0d want %0d", imem_addr, addr); end
            n_checks++; if (imem_wdata !== exp) begin n_fail++; $display("FAIL write_data: got %h want %h", imem_wdata, exp); end
            addr++; rem--; written++;
         end else begin
            n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL gap_we: got %b want 0", imem_we); end
         end
         n_checks++; if (words_written !== (ADDR_W + 1)'(written)) begin n_fail++; $display("FAIL words_running: got %0d want %0d", words_written, written); end
         guard++;
      end
      if (rem > 0) begin
         n_fail++;
         $display("FAIL burst_timeout: %0d words still outstanding", rem);
      end
      // Last write is on the port now; the FSM is draining
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready: got %b want 0", in_ready); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy: got %b want 1", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL drain_done: got %b want 0", done); end
      tick();
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b want 1", done); end
      n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL done_we: got %b want 0", imem_we); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_busy: got %b want 0", busy); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL done_err: got %b want 0", err); end
      n_checks++; if (words_written !== (ADDR_W + 1)'(cnt)) begin n_fail++; $display("FAIL done_words: got %0d want %0d", words_written, cnt); end
      tick();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_single: got %b want 0", done); end
      n_checks++; if (words_written !== (ADDR_W + 1)'(cnt)) begin n_fail++; $display("FAIL words_hold: got %0d want %0d", words_written, cnt); end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
      fmt = '0; opcode = '0; rs = '0; rt = '0; shamt = '0; func = '0; imm = '0; in1 = '0;
      repeat (3) tick();
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", imem_we); end
      n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", imem_addr); end
      n_checks++; if (imem_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
      n_checks++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b want 000", {busy, done, err}); end
      n_checks++; if (words_written !== '0) begin n_fail++; $display("FAIL reset_words: got %0d want 0", words_written); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_encoding();
      dir_q.push_back('{2'd0, 6'd0, 5'd3, 5'd5, 5'd0,  5'd1,  16'hABCD, 26'h2AAAAAA, 32'h00650001});
      dir_q.push_back('{2'd1, 6'd1, 5'd2, 5'd4, 5'h1F, 5'h1F, 16'hFFFF, 26'h1555555, 32'h0444FFFF});
      dir_q.push_back('{2'd2, 6'd5, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 16'h1234, 26'h0000040, 32'h14000040});
      dir_q.push_back('{2'd3, 6'd6, 5'd7, 5'd9, 5'h15, 5'h0A, 16'h0010, 26'h3FFFFFF, 32'h18E00010});
      vpat = '{1, 1, 1, 1};
      do_burst(0, 4, 1'b1, 1'b0);
   endtask

   task automatic test_backpressure();
      vpat = '{1, 0, 0, 1, 0, 1};
      do_burst(37, 3, 1'b0, 1'b0);
   endtask

   task automatic test_range();
      do_burst(1020, 4, 1'b0, 1'b0);
      do_burst(1021, 4, 1'b0, 1'b0);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
      do_burst(5, 2, 1'b0, 1'b0);
      do_burst(0, DEPTH + 1, 1'b0, 1'b0);
      do_burst(0, DEPTH, 1'b0, 1'b0);
   endtask

   task automatic test_zero_count();
      do_burst(12, 0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      int b, c;
      for (int i = 0; i < 6; i++) begin
         c = $urandom_range(1, 12);
         b = $urandom_range(0, DEPTH - c);
         do_burst(b, c, 1'b0, 1'b0);
      end
   endtask

   task automatic test_start_while_busy();
      do_burst(300, 6, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp;
      base_addr = ADDR_W'(100); count = (ADDR_W + 1)'(5); start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         drive_tuple(1'b0, exp);
         tick();
         n_checks++; if (imem_wdata !== exp) begin n_fail++; $display("FAIL premid_data: got %h want %h", imem_wdata, exp); end
      end
      in_valid = 1'b1;
      drive_tuple(1'b0, exp);
      #2 rst = 1'b0;
      #1;
      n_checks++; if ({in_ready, imem_we, busy, done, err} !== 5'b0) begin n_fail++; $display("FAIL async_reset_flags: got %b want 00000", {in_ready, imem_we, busy, done, err}); end
      n_checks++; if (imem_addr !== '0 || imem_wdata !== '0) begin n_fail++; $display("FAIL async_reset_port: got addr %0d data %h want 0", imem_addr, imem_wdata); end
      n_checks++; if (words_written !== '0) begin n_fail++; $display("FAIL async_reset_words: got %0d want 0", words_written); end
      tick();
      n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_no_third_write: got %b want 0", imem_we); end
      rst = 1'b1;
      in_valid = 1'b0;
      tick();
      n_checks++; if (imem_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got we %b busy %b want 0 0", imem_we, busy); end
      do_burst(100, 5, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_encoding();
      test_backpressure();
      test_range();
      test_zero_count();
      test_random();
      test_start_while_busy();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_instruction_encode
`default_nettype wire
